// File: rtl/matmul_apb_master_if.sv
// Command/response handshake plus APB bus bundle for the matmul APB master.
interface matmul_apb_master_if #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16
);
   localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [BUS_WIDTH-1:0]  cmd_wdata;
   logic [MAX_DIM-1:0]    cmd_strb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [BUS_WIDTH-1:0]  rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [BUS_WIDTH-1:0]  pwdata;
   logic [MAX_DIM-1:0]    pstrb;
   logic [BUS_WIDTH-1:0]  prdata;
   logic                  pready;
   logic                  pslverr;

   logic                  idle;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata, pstrb, idle
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
             prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata, pstrb, idle
   );
endinterface

// File: rtl/matmul_apb_master.sv
// Queued APB master: buffers commands in a small FIFO and issues them one at a
// time as SETUP/ACCESS transfers with a bounded wait, returning one response each.
module matmul_apb_master #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic                 clk,
   input logic                 rst,
   matmul_apb_master_if.master bus
);
   localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [BUS_WIDTH-1:0]  wdata;
      logic [MAX_DIM-1:0]    strb;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t                state_q;
   cmd_t                  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [WAIT_W-1:0]     wait_q;
   logic                  cmd_ready_q, idle_q;
   logic                  psel_q, penable_q, pwrite_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [BUS_WIDTH-1:0]  pwdata_q, rsp_rdata_q;
   logic [MAX_DIM-1:0]    pstrb_q;
   logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
   logic                  push_c, pop_c;
   cmd_t                  head_c;

   assign push_c = bus.cmd_valid && cmd_ready_q;
   assign pop_c  = (state_q == S_IDLE) && (count_q != '0);
   assign head_c = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   // Payload storage needs no reset; occupancy is tracked by the counter.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                              wdata: bus.cmd_wdata, strb: bus.cmd_strb};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Transfer FSM; every bus and response output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wait_q        <= '0;
         cmd_ready_q   <= 1'b0;
         idle_q        <= 1'b1;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
         unique case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  state_q  <= S_SETUP;
                  idle_q   <= 1'b0;
                  wait_q   <= '0;
                  psel_q   <= 1'b1;
                  pwrite_q <= head_c.write;
                  paddr_q  <= head_c.addr;
                  pwdata_q <= head_c.wdata;
                  pstrb_q  <= head_c.write ? head_c.strb : '0;
               end else begin
                  idle_q <= (count_d == '0);
               end
            end
            S_SETUP: begin
               state_q   <= S_ACCESS;
               penable_q <= 1'b1;
            end
            S_ACCESS: begin
               if (bus.pready) begin
                  state_q       <= S_RESP;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  pstrb_q       <= '0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                  rsp_err_q     <= bus.pslverr;
                  rsp_timeout_q <= 1'b0;
               end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                  state_q       <= S_RESP;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  pstrb_q       <= '0;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  idle_q      <= (count_d == '0);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.idle        = idle_q;
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.pstrb       = pstrb_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
endmodule
